// File: rtl/load_use_hazard_unit_pkg.sv
// rtl/load_use_hazard_unit_pkg.sv - shared pipeline types and constants for hazard control
package load_use_hazard_unit_pkg;

    localparam int REG_W = 4;

    // Encoding loaded into a pipeline register when it is bubbled or flushed.
    localparam logic [15:0] NOP_INSN = 16'h0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } fsm_t;

endpackage

// File: rtl/load_use_hazard_unit_sat_counter.sv
// rtl/load_use_hazard_unit_sat_counter.sv - saturating event counter for performance statistics
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - stall, bubble and flush control for load-use, memory waits and branches
module load_use_hazard_unit
    import load_use_hazard_unit_pkg::*;
#(
    parameter int REG_W        = load_use_hazard_unit_pkg::REG_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rsrc,
    input  logic [REG_W-1:0] id_rdst,
    input  logic             id_src_rd,
    input  logic             id_dst_rd,
    input  logic             ex_valid,
    input  logic             ex_mem_rd,
    input  logic [REG_W-1:0] ex_wb_dst,
    input  logic             mem_busy,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    fsm_t       fsm, fsm_nxt;
    logic [1:0] flush_left, flush_left_nxt;
    logic       br_pend, br_pend_nxt;
    logic       load_use;

    assign load_use = id_valid & ex_valid & ex_mem_rd &
                      ((id_src_rd & (id_rsrc == ex_wb_dst)) |
                       (id_dst_rd & (id_rdst == ex_wb_dst)));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= RUN;
            flush_left <= 2'd0;
            br_pend    <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            flush_left <= flush_left_nxt;
            br_pend    <= br_pend_nxt;
        end
    end

    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        idex_bubble    = 1'b0;
        ifid_flush     = 1'b0;
        exmem_hold     = 1'b0;
        fsm_nxt        = fsm;
        flush_left_nxt = flush_left;
        br_pend_nxt    = br_pend;

        if (!rst) begin
            if (mem_busy) begin
                // Memory stall freezes everything; a branch seen now is remembered for later.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                exmem_hold  = 1'b1;
                br_pend_nxt = br_pend | br_taken;
                if (fsm != FLUSH) begin
                    fsm_nxt = MEM_WAIT;
                end
            end else if (br_taken || br_pend) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                br_pend_nxt = 1'b0;
                if (FLUSH_CYCLES > 1) begin
                    flush_left_nxt = FLUSH_RELOAD;
                    fsm_nxt        = FLUSH;
                end else begin
                    flush_left_nxt = 2'd0;
                    fsm_nxt        = RUN;
                end
            end else if (fsm == FLUSH) begin
                // The ID instruction is dead here, so load-use is not considered.
                ifid_flush     = 1'b1;
                flush_left_nxt = flush_left - 2'd1;
                if (flush_left <= 2'd1) begin
                    flush_left_nxt = 2'd0;
                    fsm_nxt        = RUN;
                end
            end else begin
                fsm_nxt = RUN;
                if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~pc_write),
        .cnt (stall_cnt)
    );

endmodule
